// File: rtl/flight_sequencer_if.sv
// Command/status bundle between the host command unit and the arming sequencer.
// The master side drives requests and thrust; the slave (sequencer) drives status.
interface flight_sequencer_if;
    logic       arm_req;
    logic       disarm_req;
    logic       cmd_seen;
    logic [8:0] cmd_thrst;
    logic       cal_done;
    logic       vld;
    logic [8:0] thrst_out;
    logic       motors_off;
    logic       strt_cal;
    logic       inertial_cal;
    logic       failsafe;
    logic [2:0] state;

    modport master (
        output arm_req, disarm_req, cmd_seen, cmd_thrst, cal_done, vld,
        input  thrst_out, motors_off, strt_cal, inertial_cal, failsafe, state
    );

    modport slave (
        input  arm_req, disarm_req, cmd_seen, cmd_thrst, cal_done, vld,
        output thrst_out, motors_off, strt_cal, inertial_cal, failsafe, state
    );
endinterface

// File: rtl/flight_sequencer.sv
// Arming / failsafe sequencer: OFF -> CAL -> RAMP -> FLY, with a host-link
// watchdog that forces a controlled descent to zero thrust.
module flight_sequencer #(
    parameter int RAMP_STEP = 4,
    parameter int DESC_STEP = 1,
    parameter int WDOG_CYC  = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    flight_sequencer_if.slave bus
);

    localparam int            WW     = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
    localparam logic [WW-1:0] WD_MAX = WW'(WDOG_CYC - 1);
    localparam logic [9:0]    RSTEP  = 10'(RAMP_STEP);
    localparam logic [9:0]    DSTEP  = 10'(DESC_STEP);

    typedef enum logic [2:0] {
        S_OFF  = 3'd0,
        S_CAL  = 3'd1,
        S_RAMP = 3'd2,
        S_FLY  = 3'd3,
        S_DESC = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [8:0]    thrst_q, thrst_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          motors_off_q, motors_off_d;
    logic          strt_cal_q, strt_cal_d;
    logic          inertial_cal_q, inertial_cal_d;
    logic          failsafe_q, failsafe_d;
    logic          flying;
    logic          expire;
    logic [9:0]    ramp_sum;

    // 10-bit sum so the comparison against the command can never wrap.
    function automatic logic [9:0] ramp_next(input logic [8:0] t);
        return {1'b0, t} + RSTEP;
    endfunction

    // Descent saturates at zero instead of wrapping below it.
    function automatic logic [8:0] desc_next(input logic [8:0] t);
        return 9'(({1'b0, t} <= DSTEP) ? 10'd0 : ({1'b0, t} - DSTEP));
    endfunction

    always_comb begin
        state_d  = state_q;
        thrst_d  = thrst_q;
        ramp_sum = ramp_next(thrst_q);
        flying   = (state_q == S_RAMP) || (state_q == S_FLY);
        expire   = flying && !bus.cmd_seen && (wdog_q == WD_MAX);

        if (bus.disarm_req) begin
            state_d = S_OFF;
            thrst_d = '0;
        end else if (expire) begin
            state_d = S_DESC;
        end else begin
            case (state_q)
                S_OFF: begin
                    thrst_d = '0;
                    if (bus.arm_req) state_d = S_CAL;
                end
                S_CAL: begin
                    thrst_d = '0;
                    if (bus.cal_done) state_d = S_RAMP;
                end
                S_RAMP: begin
                    // A command at or below the current thrust is taken immediately.
                    if (bus.cmd_thrst <= thrst_q) begin
                        thrst_d = bus.cmd_thrst;
                        state_d = S_FLY;
                    end else if (bus.vld) begin
                        if (ramp_sum >= {1'b0, bus.cmd_thrst}) begin
                            thrst_d = bus.cmd_thrst;
                            state_d = S_FLY;
                        end else begin
                            thrst_d = ramp_sum[8:0];
                        end
                    end
                end
                S_FLY: begin
                    thrst_d = bus.cmd_thrst;
                end
                S_DESC: begin
                    if (bus.vld) begin
                        thrst_d = desc_next(thrst_q);
                        if ({1'b0, thrst_q} <= DSTEP) state_d = S_OFF;
                    end
                end
                default: begin
                    state_d = S_OFF;
                    thrst_d = '0;
                end
            endcase
        end

        // Only counts while staying within RAMP/FLY, so it reads 0 everywhere else.
        if (flying && !bus.cmd_seen && ((state_d == S_RAMP) || (state_d == S_FLY)))
            wdog_d = wdog_q + WW'(1);
        else
            wdog_d = '0;

        motors_off_d   = (state_d == S_OFF) || (state_d == S_CAL);
        inertial_cal_d = (state_d == S_CAL);
        failsafe_d     = (state_d == S_DESC);
        strt_cal_d     = (state_q == S_OFF) && (state_d == S_CAL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_OFF;
            thrst_q        <= '0;
            wdog_q         <= '0;
            motors_off_q   <= 1'b1;
            strt_cal_q     <= 1'b0;
            inertial_cal_q <= 1'b0;
            failsafe_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            thrst_q        <= thrst_d;
            wdog_q         <= wdog_d;
            motors_off_q   <= motors_off_d;
            strt_cal_q     <= strt_cal_d;
            inertial_cal_q <= inertial_cal_d;
            failsafe_q     <= failsafe_d;
        end
    end

    assign bus.thrst_out    = thrst_q;
    assign bus.motors_off   = motors_off_q;
    assign bus.strt_cal     = strt_cal_q;
    assign bus.inertial_cal = inertial_cal_q;
    assign bus.failsafe     = failsafe_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_flight_sequencer.sv
// Bench for flight_sequencer: directed table, hand-written corner sequences and
// randomized traffic checked against a behavioural model of the sequencing rules.
module tb_flight_sequencer;

    localparam int RS = 4;
    localparam int DS = 2;
    localparam int WD = 100;

    typedef struct {
        logic       arm;
        logic       disarm;
        logic       seen;
        logic [8:0] cmd;
        logic       cal;
        logic       vld;
    } in_t;

    typedef struct {
        in_t i;
        int  st;
        int  thr;
        int  strt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: mode 0..4, thrust, and consecutive silent cycles in flight.
    int m_state, m_thr, m_quiet, m_strt;

    vec_t tbl[$];

    flight_sequencer_if bus();

    flight_sequencer #(
        .RAMP_STEP(RS),
        .DESC_STEP(DS),
        .WDOG_CYC (WD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    function automatic in_t mk(input bit arm, input bit disarm, input bit seen,
                               input int cmd, input bit cal, input bit vld);
        in_t r;
        r.arm = arm; r.disarm = disarm; r.seen = seen;
        r.cmd = 9'(cmd); r.cal = cal; r.vld = vld;
        return r;
    endfunction

    function automatic void add(input in_t i, input int st, input int thr, input int strt);
        vec_t v;
        v.i = i; v.st = st; v.thr = thr; v.strt = strt;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_state = 0; m_thr = 0; m_quiet = 0; m_strt = 0;
    endfunction

    function automatic void model_step(input in_t i);
        int ns, nt, cmd;
        bit in_air, exp_wd;
        ns = m_state; nt = m_thr; cmd = int'(i.cmd);
        in_air = (m_state == 2) || (m_state == 3);
        exp_wd = in_air && !i.seen && (m_quiet >= WD - 1);
        if (i.disarm) begin
            ns = 0; nt = 0;
        end else if (exp_wd) begin
            ns = 4;
        end else if (m_state == 0) begin
            if (i.arm) ns = 1;
        end else if (m_state == 1) begin
            if (i.cal) begin ns = 2; nt = 0; end
        end else if (m_state == 2) begin
            if (cmd <= m_thr) begin
                nt = cmd; ns = 3;
            end else if (i.vld) begin
                nt = (m_thr + RS < cmd) ? m_thr + RS : cmd;
                if (nt == cmd) ns = 3;
            end
        end else if (m_state == 3) begin
            nt = cmd;
        end else begin
            if (i.vld) begin
                nt = (m_thr > DS) ? m_thr - DS : 0;
                if (m_thr <= DS) ns = 0;
            end
        end
        m_quiet = (in_air && (ns == 2 || ns == 3) && !i.seen) ? m_quiet + 1 : 0;
        m_strt  = (m_state == 0 && ns == 1) ? 1 : 0;
        m_state = ns;
        m_thr   = nt;
    endfunction

    task automatic compare_model();
        chk("m_state", bus.state, m_state);
        chk("m_thrst", bus.thrst_out, m_thr);
        chk("m_motors_off", bus.motors_off, (m_state <= 1) ? 1 : 0);
        chk("m_strt_cal", bus.strt_cal, m_strt);
        chk("m_inertial_cal", bus.inertial_cal, (m_state == 1) ? 1 : 0);
        chk("m_failsafe", bus.failsafe, (m_state == 4) ? 1 : 0);
    endtask

    task automatic drive(input in_t i);
        @(negedge clk);
        bus.arm_req    = i.arm;
        bus.disarm_req = i.disarm;
        bus.cmd_seen   = i.seen;
        bus.cmd_thrst  = i.cmd;
        bus.cal_done   = i.cal;
        bus.vld        = i.vld;
        @(posedge clk);
        #1;
        model_step(i);
        compare_model();
    endtask

    initial begin
        int n;
        int cmd_r;
        int dexp[5];
        in_t r;

        bus.arm_req = 0; bus.disarm_req = 0; bus.cmd_seen = 0;
        bus.cmd_thrst = '0; bus.cal_done = 0; bus.vld = 0;
        model_reset();

        // Directed table: arming, ramp, FLY tracking, arm+disarm collision, ramp drop.
        add(mk(1,0,0,0,0,0),   1, 0, 1);
        add(mk(0,0,0,0,0,0),   1, 0, 0);
        add(mk(0,0,0,10,1,0),  2, 0, 0);
        add(mk(0,0,0,10,0,1),  2, 4, 0);
        add(mk(0,0,0,10,0,0),  2, 4, 0);
        add(mk(0,0,0,10,0,1),  2, 8, 0);
        add(mk(0,0,0,10,0,1),  3, 10, 0);
        add(mk(0,0,1,10,0,0),  3, 10, 0);
        add(mk(0,0,0,25,0,0),  3, 25, 0);
        add(mk(1,1,0,25,0,0),  0, 0, 0);
        add(mk(0,0,0,25,0,0),  0, 0, 0);
        add(mk(0,1,0,0,0,0),   0, 0, 0);
        add(mk(1,0,0,0,0,0),   1, 0, 1);
        add(mk(0,0,0,200,1,0), 2, 0, 0);
        for (int k = 1; k <= 10; k++) add(mk(0,0,0,200,0,1), 2, 4 * k, 0);
        add(mk(0,0,0,20,0,0),  3, 20, 0);
        add(mk(0,0,1,20,0,0),  3, 20, 0);
        add(mk(0,0,0,0,0,0),   3, 0, 0);
        add(mk(0,1,0,0,0,0),   0, 0, 0);

        repeat (3) @(negedge clk);
        chk("rst_state", bus.state, 0);
        chk("rst_thrst", bus.thrst_out, 0);
        chk("rst_motors_off", bus.motors_off, 1);
        chk("rst_strt_cal", bus.strt_cal, 0);
        chk("rst_inertial_cal", bus.inertial_cal, 0);
        chk("rst_failsafe", bus.failsafe, 0);
        rst = 1'b0;

        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].i);
            chk($sformatf("row%0d_state", k), bus.state, tbl[k].st);
            chk($sformatf("row%0d_thrst", k), bus.thrst_out, tbl[k].thr);
            chk($sformatf("row%0d_motors_off", k), bus.motors_off, (tbl[k].st <= 1) ? 1 : 0);
            chk($sformatf("row%0d_strt_cal", k), bus.strt_cal, tbl[k].strt);
            chk($sformatf("row%0d_inertial_cal", k), bus.inertial_cal, (tbl[k].st == 1) ? 1 : 0);
        end

        // Watchdog kept alive for 1000 cycles, then silence until failsafe.
        drive(mk(1,0,0,10,0,0));
        drive(mk(0,0,0,10,1,0));
        repeat (3) drive(mk(0,0,0,10,0,1));
        chk("fly_state", bus.state, 3);
        for (int c = 0; c < 1000; c++) begin
            drive(mk(0,0,(c % 50) == 49,10,0,0));
            chk("wd_alive_failsafe", bus.failsafe, 0);
        end
        n = 0;
        while (n <= 200) begin
            n++;
            drive(mk(0,0,0,10,0,0));
            if (bus.state == 3'd4) break;
        end
        chk("wd_expiry_cycles", n, 100);
        dexp[0] = 8; dexp[1] = 6; dexp[2] = 4; dexp[3] = 2; dexp[4] = 0;
        for (int k = 0; k < 5; k++) begin
            drive(mk(0,0,1,300,0,0));
            chk("desc_hold_thrst", bus.thrst_out, (k == 0) ? 10 : dexp[k - 1]);
            drive(mk(0,0,1,300,0,1));
            chk("desc_thrst", bus.thrst_out, dexp[k]);
            chk("desc_state", bus.state, (k == 4) ? 0 : 4);
        end
        chk("desc_end_motors_off", bus.motors_off, 1);

        // Expiry cycle coinciding with cmd_seen, then descent entered at zero thrust.
        drive(mk(1,0,0,0,0,0));
        drive(mk(0,0,0,0,1,0));
        drive(mk(0,0,0,0,0,0));
        drive(mk(0,0,1,50,0,0));
        repeat (99) drive(mk(0,0,0,50,0,0));
        chk("tie_pre_state", bus.state, 3);
        drive(mk(0,0,1,50,0,0));
        chk("tie_state", bus.state, 3);
        chk("tie_failsafe", bus.failsafe, 0);
        repeat (100) drive(mk(0,0,0,0,0,0));
        chk("zero_desc_state", bus.state, 4);
        chk("zero_desc_thrst", bus.thrst_out, 0);
        drive(mk(0,0,0,0,0,1));
        chk("zero_desc_off", bus.state, 0);

        // Asynchronous reset between clock edges while flying.
        drive(mk(1,0,0,0,0,0));
        drive(mk(0,0,0,100,1,0));
        drive(mk(0,0,1,0,0,0));
        drive(mk(0,0,0,100,0,0));
        chk("pre_arst_thrst", bus.thrst_out, 100);
        #2 rst = 1'b1;
        #1;
        chk("arst_state", bus.state, 0);
        chk("arst_thrst", bus.thrst_out, 0);
        chk("arst_motors_off", bus.motors_off, 1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic against the model.
        cmd_r = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(24) == 0) begin
                case ($urandom_range(3))
                    0: cmd_r = 0;
                    1: cmd_r = 511;
                    default: cmd_r = int'($urandom_range(511));
                endcase
            end
            r = mk($urandom_range(19) == 0, $urandom_range(149) == 0,
                   $urandom_range(39) == 0, cmd_r,
                   $urandom_range(7) == 0, $urandom_range(2) == 0);
            drive(r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
